// File: rtl/mld_7_4_controller_pkg.sv
// Shared constants and state encoding for the (7,4) MLD sequencer.
package mld_7_4_pkg;
  localparam int N     = 7;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/mld_7_4_controller_if.sv
// Channel input, decoder link and result output of the MLD sequencer.
interface mld_7_4_controller_if;
  import mld_7_4_pkg::*;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         dec_load;
  logic         dec_bit;
  logic [0:N-1] dec_vector;
  logic         out_valid;
  logic         out_ready;
  logic [0:N-1] out_codeword;
  logic         out_corrected;
  logic         busy;

  modport master (
    input  in_valid, in_bit, dec_vector, out_ready,
    output in_ready, dec_load, dec_bit, out_valid, out_codeword, out_corrected, busy
  );
  modport slave (
    output in_valid, in_bit, dec_vector, out_ready,
    input  in_ready, dec_load, dec_bit, out_valid, out_codeword, out_corrected, busy
  );
endinterface

// File: rtl/mld_7_4_controller_sipo.sv
// Serial-in buffer: bit k lands at buf[N-1-k]; full after bit N-1 until cleared.
module mld_sipo_buffer
  import mld_7_4_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic         i_bit,
  input  logic         i_clear,
  output logic         o_ready,
  output logic [0:N-1] o_buf,
  output logic         o_full
);
  logic [CNT_W-1:0] r_idx;
  logic [0:N-1]     r_buf;
  logic             r_full;
  logic             w_accept;

  assign w_accept = i_valid && !r_full;
  assign o_ready  = !r_full;
  assign o_buf    = r_buf;
  assign o_full   = r_full;

  // Clear only arrives while full, so it never collides with an accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx  <= '0;
      r_buf  <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_buf[CNT_LAST - r_idx] <= i_bit;
      if (r_idx == CNT_LAST) begin
        r_idx  <= '0;
        r_full <= 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end
endmodule

// File: rtl/mld_7_4_controller.sv
// Sequencer: buffers a received word, replays it into the MLD, then captures the fix.
module mld_7_4_controller
  import mld_7_4_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mld_7_4_controller_if.master bus
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [0:N-1]     r_work, r_raw, r_code;
  logic             r_valid, r_corr;
  logic [0:N-1]     w_buf;
  logic             w_full, w_start, w_in_ready;

  assign w_start = (r_state == IDLE) && w_full && !r_valid;

  mld_sipo_buffer u_sipo (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.in_valid),
    .i_bit   (bus.in_bit),
    .i_clear (w_start),
    .o_ready (w_in_ready),
    .o_buf   (w_buf),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = LOAD;
      LOAD:    if (r_cnt == CNT_LAST) w_next = DECODE;
      DECODE:  if (r_cnt == CNT_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_work  <= '0;
      r_raw   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_corr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_work <= w_buf;
          r_raw  <= w_buf;
          r_cnt  <= '0;
        end
        LOAD, DECODE: r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        DONE: begin
          r_code <= bus.dec_vector;
          r_corr <= |(bus.dec_vector ^ r_raw);
        end
        default: ;
      endcase
      // DONE is only reachable with the output slot empty.
      if (r_state == DONE)                 r_valid <= 1'b1;
      else if (r_valid && bus.out_ready)   r_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.in_ready      = w_in_ready;
    bus.dec_load      = (r_state == LOAD);
    bus.dec_bit       = (r_state == LOAD) ? r_work[CNT_LAST - r_cnt] : 1'b0;
    bus.busy          = (r_state != IDLE);
    bus.out_valid     = r_valid;
    bus.out_codeword  = r_code;
    bus.out_corrected = r_corr;
  end
endmodule
